bram_port_arb: RTL and testbench

- Shares one 32-bit BRAM port (1-cycle read latency, byte-addressed, word step 4) between NUM_REQ PL requesters.
- Each requester posts a burst descriptor: read/write, start byte address, byte length.
- The block arbitrates round-robin and sequences the burst onto the port one word per cycle.
- It routes read data back to the requester and pulls write data from it, ending each burst with a done pulse.

---
 rtl/bram_port_arb_pkg.sv | 50 +++++
 rtl/bram_port_arb_if.sv | 48 ++++
 rtl/bram_port_arb_rr_arbiter.sv | 31 +++
 rtl/bram_port_arb.sv | 170 +++++++++++++++++
 tb/tb_bram_port_arb.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/bram_port_arb_pkg.sv
`timescale 1ns/1ps
// Shared types, widths and round-robin helpers for the BRAM port arbiter.
package bram_arb_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned LEN_W      = 32;
    localparam int unsigned WORDS_W    = 30;
    localparam int unsigned MAX_REQ    = 4;
    localparam int unsigned IDX_W      = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_TAIL  = 2'd2
    } arb_state_e;

    // Context of the burst currently owning the port.
    typedef struct packed {
        logic               write;
        logic               err;
        logic [IDX_W-1:0]   idx;
        logic [WORDS_W-1:0] rem;
    } burst_ctx_t;

    // First requesting index at or after ptr, modulo num.
    function automatic logic [IDX_W-1:0] rr_next_grant(input logic [MAX_REQ-1:0] req,
                                                       input logic [IDX_W-1:0]   ptr,
                                                       input int unsigned        num);
        logic [IDX_W-1:0] pick;
        logic             found;
        int unsigned      j;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            j = (32'(ptr) + k) % num;
            if (!found && (k < num) && req[j[IDX_W-1:0]]) begin
                pick  = j[IDX_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [IDX_W-1:0] rr_wrap_inc(input logic [IDX_W-1:0] idx,
                                                     input int unsigned      num);
        return IDX_W'((32'(idx) + 32'd1) % num);
    endfunction

endpackage

// File: rtl/bram_port_arb_if.sv
`timescale 1ns/1ps
// Requester bus plus BRAM port bundle; master = arbiter side, slave = requesters/BRAM.
// err exists only when BRAM_ARB_CHECK_EN is defined.
interface bram_port_arb_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned AW      = 32
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_write;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*32-1:0] req_len;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] wr_data;
    logic [NUM_REQ-1:0]    wr_pull;
    logic [31:0]           rd_data;
    logic [NUM_REQ-1:0]    rd_valid;
    logic [NUM_REQ-1:0]    done;
    logic                  busy;
`ifdef BRAM_ARB_CHECK_EN
    logic [NUM_REQ-1:0]    err;
`endif
    logic                  ram_clk;
    logic                  ram_rst;
    logic                  ram_en;
    logic [3:0]            ram_we;
    logic [AW-1:0]         ram_addr;
    logic [31:0]           ram_wr_data;
    logic [31:0]           ram_rd_data;

    modport master (
        input  req_valid, req_write, req_addr, req_len, wr_data, ram_rd_data,
        output req_ready, wr_pull, rd_data, rd_valid, done, busy,
`ifdef BRAM_ARB_CHECK_EN
               err,
`endif
               ram_clk, ram_rst, ram_en, ram_we, ram_addr, ram_wr_data
    );

    modport slave (
        output req_valid, req_write, req_addr, req_len, wr_data, ram_rd_data,
        input  req_ready, wr_pull, rd_data, rd_valid, done, busy,
`ifdef BRAM_ARB_CHECK_EN
               err,
`endif
               ram_clk, ram_rst, ram_en, ram_we, ram_addr, ram_wr_data
    );

endinterface

// File: rtl/bram_port_arb_rr_arbiter.sv
`timescale 1ns/1ps
// Round-robin priority rotate; pointer moves past the winner when advance_i is set.
module rr_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] gnt_oh_c_o,
    output logic [IDX_W-1:0]   gnt_idx_c_o,
    output logic               gnt_valid_c_o
);

    logic [IDX_W-1:0] ptr_q, ptr_d;

    always_comb begin
        gnt_idx_c_o   = rr_next_grant(MAX_REQ'(req_i), ptr_q, NUM_REQ);
        gnt_valid_c_o = |req_i;
        gnt_oh_c_o    = gnt_valid_c_o ? (NUM_REQ'(1'b1) << gnt_idx_c_o) : '0;
        ptr_d         = advance_i ? rr_wrap_inc(gnt_idx_c_o, NUM_REQ) : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/bram_port_arb.sv
`timescale 1ns/1ps
// Shares one 32-bit BRAM port among NUM_REQ burst requesters, one word per cycle.
// Define BRAM_ARB_CHECK_EN to reject short/misaligned bursts with an err pulse.
module bram_port_arb
    import bram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned AW      = 32
) (
    input logic             clk,
    input logic             rst_n,
    bram_port_arb_if.master bus
);

    arb_state_e         state_q, state_d;
    burst_ctx_t         ctx_q, ctx_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d, wr_pull_q, wr_pull_d;
    logic [NUM_REQ-1:0] rd_valid_q, rd_valid_d, done_q, done_d, err_q, err_d;
    logic               busy_q, busy_d, ram_en_q, ram_en_d;
    logic [3:0]         ram_we_q, ram_we_d;
    logic [AW-1:0]      ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]  ram_wr_data_q, ram_wr_data_d;

    logic [NUM_REQ-1:0] gnt_oh, cur_oh;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_valid, gnt_write, bad_req;
    logic [AW-1:0]      sel_addr;
    logic [LEN_W-1:0]   sel_len;
    logic [DATA_W-1:0]  sel_wdata, cur_wdata;
    logic [WORDS_W-1:0] sel_words;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_i         (bus.req_valid),
        .advance_i     ((state_q == ST_IDLE) && gnt_valid),
        .gnt_oh_c_o    (gnt_oh),
        .gnt_idx_c_o   (gnt_idx),
        .gnt_valid_c_o (gnt_valid)
    );

    // Descriptor of the candidate winner and write word of the current owner.
    always_comb begin
        sel_addr  = bus.req_addr[32'(gnt_idx)*AW +: AW];
        sel_len   = bus.req_len[32'(gnt_idx)*LEN_W +: LEN_W];
        sel_wdata = bus.wr_data[32'(gnt_idx)*DATA_W +: DATA_W];
        gnt_write = |(bus.req_write & gnt_oh);
        sel_words = WORDS_W'(sel_len >> 2);
        cur_wdata = bus.wr_data[32'(ctx_q.idx)*DATA_W +: DATA_W];
        cur_oh    = NUM_REQ'(1'b1) << ctx_q.idx;
`ifdef BRAM_ARB_CHECK_EN
        bad_req   = (sel_len < LEN_W'(WORD_BYTES)) || (sel_len[1:0] != 2'b00) ||
                    (sel_addr[1:0] != 2'b00);
`else
        bad_req   = 1'b0;
`endif
    end

    always_comb begin
        state_d       = state_q;
        ctx_d         = ctx_q;
        req_ready_d   = '0;
        wr_pull_d     = '0;
        done_d        = '0;
        err_d         = '0;
        rd_valid_d    = (ram_en_q && !ctx_q.write) ? cur_oh : '0;
        busy_d        = busy_q;
        ram_en_d      = ram_en_q;
        ram_we_d      = ram_we_q;
        ram_addr_d    = ram_addr_q;
        ram_wr_data_d = ram_wr_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    req_ready_d = gnt_oh;
                    busy_d      = 1'b1;
                    ctx_d.write = gnt_write;
                    ctx_d.err   = bad_req;
                    ctx_d.idx   = gnt_idx;
                    ctx_d.rem   = (sel_words == '0) ? '0 : sel_words - WORDS_W'(1);
                    state_d     = ST_BURST;
                    if (!bad_req) begin
                        ram_en_d      = 1'b1;
                        ram_addr_d    = sel_addr;
                        ram_we_d      = gnt_write ? 4'hF : 4'h0;
                        ram_wr_data_d = sel_wdata;
                        wr_pull_d     = gnt_write ? gnt_oh : '0;
                    end
                end
            end
            ST_BURST: begin
                if (ctx_q.err) begin
                    done_d  = cur_oh;
                    err_d   = cur_oh;
                    state_d = ST_TAIL;
                end else if (ctx_q.rem == '0) begin
                    ram_en_d   = 1'b0;
                    ram_we_d   = 4'h0;
                    ram_addr_d = '0;
                    done_d     = cur_oh;
                    state_d    = ST_TAIL;
                end else begin
                    ram_addr_d = ram_addr_q + AW'(WORD_BYTES);
                    ctx_d.rem  = ctx_q.rem - WORDS_W'(1);
                    if (ctx_q.write) begin
                        ram_wr_data_d = cur_wdata;
                        wr_pull_d     = cur_oh;
                    end
                end
            end
            ST_TAIL: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ctx_q         <= '0;
            req_ready_q   <= '0;
            wr_pull_q     <= '0;
            rd_valid_q    <= '0;
            done_q        <= '0;
            err_q         <= '0;
            busy_q        <= 1'b0;
            ram_en_q      <= 1'b0;
            ram_we_q      <= 4'h0;
            ram_addr_q    <= '0;
            ram_wr_data_q <= '0;
        end else begin
            state_q       <= state_d;
            ctx_q         <= ctx_d;
            req_ready_q   <= req_ready_d;
            wr_pull_q     <= wr_pull_d;
            rd_valid_q    <= rd_valid_d;
            done_q        <= done_d;
            err_q         <= err_d;
            busy_q        <= busy_d;
            ram_en_q      <= ram_en_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_wr_data_q <= ram_wr_data_d;
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.wr_pull     = wr_pull_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.done        = done_q;
    assign bus.busy        = busy_q;
    assign bus.rd_data     = bus.ram_rd_data;
    assign bus.ram_clk     = clk;
    assign bus.ram_rst     = 1'b0;
    assign bus.ram_en      = ram_en_q;
    assign bus.ram_we      = ram_we_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_wr_data = ram_wr_data_q;
`ifdef BRAM_ARB_CHECK_EN
    assign bus.err         = err_q;
`else
    // err_q only ever carries the checked-build flag; keep it observable in the port-less build.
    logic unused_err;
    assign unused_err = ^err_q;
`endif

endmodule

// File: tb/tb_bram_port_arb.sv
`timescale 1ns/1ps
// Directed bench for bram_port_arb with a small BRAM read model and requester model.
module tb_bram_port_arb;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned AW      = 32;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        hold  = 1'b0;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] wbase [NUM_REQ];
    logic [31:0] widx  [NUM_REQ];
`ifdef BRAM_ARB_CHECK_EN
    logic [1:0]  exp_err = 2'b00;
`endif

    always #5 clk = ~clk;

    bram_port_arb_if #(.NUM_REQ(NUM_REQ), .AW(AW)) bus ();

    bram_port_arb #(.NUM_REQ(NUM_REQ), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // BRAM read model with one cycle of latency.
    always @(posedge clk) if (bus.ram_en) bus.ram_rd_data <= pat(bus.ram_addr);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic post(input int i, input logic wr, input logic [31:0] addr,
                        input logic [31:0] len, input logic [31:0] wb);
        bus.req_valid[i]          = 1'b1;
        bus.req_write[i]          = wr;
        bus.req_addr[i*AW +: AW]  = addr;
        bus.req_len[i*32 +: 32]   = len;
        wbase[i]                  = wb;
        widx[i]                   = 32'd0;
        bus.wr_data[i*32 +: 32]   = wb;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".rdy"},  64'(bus.req_ready),   64'd0);
        chk({tag, ".pull"}, 64'(bus.wr_pull),     64'd0);
        chk({tag, ".rdv"},  64'(bus.rd_valid),    64'd0);
        chk({tag, ".done"}, 64'(bus.done),        64'd0);
        chk({tag, ".busy"}, 64'(bus.busy),        64'd0);
        chk({tag, ".en"},   64'(bus.ram_en),      64'd0);
        chk({tag, ".we"},   64'(bus.ram_we),      64'd0);
        chk({tag, ".addr"}, 64'(bus.ram_addr),    64'd0);
        chk({tag, ".wd"},   64'(bus.ram_wr_data), 64'd0);
        chk({tag, ".rrst"}, 64'(bus.ram_rst),     64'd0);
`ifdef BRAM_ARB_CHECK_EN
        chk({tag, ".err"},  64'(bus.err),         64'd0);
`endif
    endtask

    // Check one cycle, then let the requesters react and advance to the next cycle.
    task automatic exp_cyc(input string tag, input logic [1:0] rdy, input logic en,
                           input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [1:0] pull, input logic [1:0] rdv, input logic [31:0] rdd,
                           input logic [1:0] dn, input logic bsy);
        chk({tag, ".rdy"},  64'(bus.req_ready), 64'(rdy));
        chk({tag, ".en"},   64'(bus.ram_en),    64'(en));
        chk({tag, ".we"},   64'(bus.ram_we),    64'(we));
        chk({tag, ".addr"}, 64'(bus.ram_addr),  64'(addr));
        chk({tag, ".pull"}, 64'(bus.wr_pull),   64'(pull));
        chk({tag, ".rdv"},  64'(bus.rd_valid),  64'(rdv));
        chk({tag, ".done"}, 64'(bus.done),      64'(dn));
        chk({tag, ".busy"}, 64'(bus.busy),      64'(bsy));
        if (we != 4'h0) chk({tag, ".wd"}, 64'(bus.ram_wr_data), 64'(wd));
        if (rdv != 2'b00) chk({tag, ".rdd"}, 64'(bus.rd_data), 64'(rdd));
`ifdef BRAM_ARB_CHECK_EN
        chk({tag, ".err"},  64'(bus.err),       64'(exp_err));
`endif
        if (!hold) bus.req_valid = bus.req_valid & ~bus.req_ready;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.wr_pull[i]) begin
                widx[i] = widx[i] + 32'd1;
                bus.wr_data[i*32 +: 32] = wbase[i] + widx[i];
            end
        end
        tick();
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.wr_data   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            wbase[i] = 32'd0;
            widx[i]  = 32'd0;
        end

        // Reset state
        tick();
        tick();
        chk_zero("reset");
        chk("reset.ram_clk", 64'(bus.ram_clk), 64'd1);
        rst_n = 1'b1;
        tick();

        // Single read: 4 words from 0x100, done with the last rd_valid
        post(0, 1'b0, 32'h100, 32'd16, 32'd0);
        tick();
        exp_cyc("rd.c1", 2'b01, 1, 4'h0, 32'h100, 0, 2'b00, 2'b00, 0,              2'b00, 1);
        exp_cyc("rd.c2", 2'b00, 1, 4'h0, 32'h104, 0, 2'b00, 2'b01, pat(32'h100), 2'b00, 1);
        exp_cyc("rd.c3", 2'b00, 1, 4'h0, 32'h108, 0, 2'b00, 2'b01, pat(32'h104), 2'b00, 1);
        exp_cyc("rd.c4", 2'b00, 1, 4'h0, 32'h10C, 0, 2'b00, 2'b01, pat(32'h108), 2'b00, 1);
        exp_cyc("rd.c5", 2'b00, 0, 4'h0, 32'h0,   0, 2'b00, 2'b01, pat(32'h10C), 2'b01, 1);
        exp_cyc("rd.c6", 2'b00, 0, 4'h0, 32'h0,   0, 2'b00, 2'b00, 0,              2'b00, 0);

        // Single write: 2 words from requester 1
        post(1, 1'b1, 32'h40, 32'd8, 32'hA5A5_0001);
        tick();
        exp_cyc("wr.c1", 2'b10, 1, 4'hF, 32'h40, 32'hA5A5_0001, 2'b10, 2'b00, 0, 2'b00, 1);
        exp_cyc("wr.c2", 2'b00, 1, 4'hF, 32'h44, 32'hA5A5_0002, 2'b10, 2'b00, 0, 2'b00, 1);
        exp_cyc("wr.c3", 2'b00, 0, 4'h0, 32'h0,  0,             2'b00, 2'b00, 0, 2'b10, 1);
        exp_cyc("wr.c4", 2'b00, 0, 4'h0, 32'h0,  0,             2'b00, 2'b00, 0, 2'b00, 0);

        // Both requesters held: single-word bursts alternate 0,1,0,1
        hold = 1'b1;
        post(0, 1'b0, 32'h200, 32'd4, 32'd0);
        post(1, 1'b0, 32'h300, 32'd4, 32'd0);
        tick();
        for (int r = 0; r < 2; r++) begin
            for (int g = 0; g < 2; g++) begin
                exp_cyc($sformatf("rr%0d.g%0d", r, g), 2'(1 << g), 1, 4'h0,
                        32'h200 + 32'(g) * 32'h100, 0, 2'b00, 2'b00, 0, 2'b00, 1);
                if (r == 1 && g == 1) begin
                    hold          = 1'b0;
                    bus.req_valid = '0;
                end
                exp_cyc($sformatf("rr%0d.t%0d", r, g), 2'b00, 0, 4'h0, 32'h0, 0, 2'b00,
                        2'(1 << g), pat(32'h200 + 32'(g) * 32'h100), 2'(1 << g), 1);
                exp_cyc($sformatf("rr%0d.i%0d", r, g), 2'b00, 0, 4'h0, 32'h0, 0, 2'b00,
                        2'b00, 0, 2'b00, 0);
            end
        end

        // Zero length
        post(0, 1'b0, 32'h80, 32'd0, 32'd0);
        tick();
`ifdef BRAM_ARB_CHECK_EN
        exp_cyc("z.c1", 2'b01, 0, 4'h0, 32'h0, 0, 2'b00, 2'b00, 0, 2'b00, 1);
        exp_err = 2'b01;
        exp_cyc("z.c2", 2'b00, 0, 4'h0, 32'h0, 0, 2'b00, 2'b00, 0, 2'b01, 1);
        exp_err = 2'b00;
        exp_cyc("z.c3", 2'b00, 0, 4'h0, 32'h0, 0, 2'b00, 2'b00, 0, 2'b00, 0);
`else
        exp_cyc("z.c1", 2'b01, 1, 4'h0, 32'h80, 0, 2'b00, 2'b00, 0,            2'b00, 1);
        exp_cyc("z.c2", 2'b00, 0, 4'h0, 32'h0,  0, 2'b00, 2'b01, pat(32'h80), 2'b01, 1);
        exp_cyc("z.c3", 2'b00, 0, 4'h0, 32'h0,  0, 2'b00, 2'b00, 0,            2'b00, 0);
`endif

        // Address wrap at the top of the byte space
        post(1, 1'b0, 32'hFFFF_FFFC, 32'd8, 32'd0);
        tick();
        exp_cyc("wrap.c1", 2'b10, 1, 4'h0, 32'hFFFF_FFFC, 0, 2'b00, 2'b00, 0,                   2'b00, 1);
        exp_cyc("wrap.c2", 2'b00, 1, 4'h0, 32'h0,         0, 2'b00, 2'b10, pat(32'hFFFF_FFFC), 2'b00, 1);
        exp_cyc("wrap.c3", 2'b00, 0, 4'h0, 32'h0,         0, 2'b00, 2'b10, pat(32'h0),         2'b10, 1);
        exp_cyc("wrap.c4", 2'b00, 0, 4'h0, 32'h0,         0, 2'b00, 2'b00, 0,                   2'b00, 0);

        // Reset in the middle of a 16-word read
        post(0, 1'b0, 32'h400, 32'd64, 32'd0);
        tick();
        exp_cyc("rst.c1", 2'b01, 1, 4'h0, 32'h400, 0, 2'b00, 2'b00, 0,              2'b00, 1);
        exp_cyc("rst.c2", 2'b00, 1, 4'h0, 32'h404, 0, 2'b00, 2'b01, pat(32'h400), 2'b00, 1);
        exp_cyc("rst.c3", 2'b00, 1, 4'h0, 32'h408, 0, 2'b00, 2'b01, pat(32'h404), 2'b00, 1);
        rst_n = 1'b0;
        #1;
        chk_zero("rst.now");
        tick();
        chk_zero("rst.hold1");
        tick();
        chk_zero("rst.hold2");
        rst_n = 1'b1;
        tick();
        chk_zero("rst.after");

        // After reset the pointer is back at requester 0
        post(0, 1'b0, 32'h500, 32'd4, 32'd0);
        post(1, 1'b0, 32'h600, 32'd4, 32'd0);
        tick();
        exp_cyc("post.c1", 2'b01, 1, 4'h0, 32'h500, 0, 2'b00, 2'b00, 0, 2'b00, 1);
        bus.req_valid = '0;
        exp_cyc("post.c2", 2'b00, 0, 4'h0, 32'h0, 0, 2'b00, 2'b01, pat(32'h500), 2'b01, 1);
        exp_cyc("post.c3", 2'b00, 0, 4'h0, 32'h0, 0, 2'b00, 2'b00, 0,            2'b00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
